// File: rtl/raizing_gfx_rom_server_pkg.sv
// ----------------------------------------------------------------------------
// raizing_gfx_pkg
//   Shared definitions for the Raizing graphics ROM server:
//     - channel count and channel indices (OBJ, SCR0, SCR1, SCR2)
//     - FSM state encoding of the memory-request sequencer
//     - default address / data widths
//   The optional OBJ-priority arbitration is selected with the macro
//   RAIZING_GFXSRV_OBJ_PRIO_EN (consumed by raizing_rr_arb4).
// ----------------------------------------------------------------------------
package raizing_gfx_pkg;

    localparam int NCH     = 4;
    localparam int CH_OBJ  = 0;
    localparam int CH_SCR0 = 1;
    localparam int CH_SCR1 = 2;
    localparam int CH_SCR2 = 3;

    localparam int DEF_AW  = 22;
    localparam int DEF_DW  = 32;

    // Sequencer states. Encoding is exported on DBG_STATE of the top.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Channel index reached by stepping k positions after ptr (mod 4).
    function automatic logic [1:0] rr_step(input logic [1:0] ptr, input int k);
        return ptr + 2'(k);
    endfunction

endpackage

// File: rtl/raizing_gfx_rom_server_arb.sv
// ----------------------------------------------------------------------------
// raizing_rr_arb4
//   Combinational 4-way round-robin arbiter.
//   The search starts at rr_ptr+1 (mod 4) and wraps, so the channel served
//   last has the lowest priority on the next pick.
//
//   Optional feature (macro RAIZING_GFXSRV_OBJ_PRIO_EN):
//     channel 0 (OBJ) wins whenever it is pending; channels 1..3 share the
//     round-robin among themselves.
//
//   Ports:
//     pending   in  4  request vector (bit i = channel i needs memory)
//     rr_ptr    in  2  index of the channel granted most recently
//     grant_oh  out 4  one-hot grant (zero when nothing is pending)
//     grant_idx out 2  binary index of the grant
//     grant_any out 1  at least one channel granted
// ----------------------------------------------------------------------------
module raizing_rr_arb4
    import raizing_gfx_pkg::*;
(
    input  logic [NCH-1:0] pending,
    input  logic [1:0]     rr_ptr,
    output logic [NCH-1:0] grant_oh,
    output logic [1:0]     grant_idx,
    output logic           grant_any
);

    logic [NCH-1:0] rr_pool;
    logic [1:0]     cand;

    always_comb begin
        rr_pool   = pending;
        cand      = '0;
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;

`ifdef RAIZING_GFXSRV_OBJ_PRIO_EN
        // OBJ bypasses the rotation entirely; remove it from the pool so the
        // scroll layers rotate only among themselves.
        if (pending[CH_OBJ]) begin
            grant_oh[CH_OBJ] = 1'b1;
            grant_idx        = 2'(CH_OBJ);
            grant_any        = 1'b1;
        end
        rr_pool[CH_OBJ] = 1'b0;
`endif

        // k = 1..4: the last candidate is rr_ptr itself.
        for (int k = 1; k <= NCH; k++) begin
            cand = rr_step(rr_ptr, k);
            if (!grant_any && rr_pool[cand]) begin
                grant_oh[cand] = 1'b1;
                grant_idx      = cand;
                grant_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/raizing_gfx_rom_server.sv
// ----------------------------------------------------------------------------
// raizing_gfx_rom_server
//   Memory-side responder for the four graphics ROM request channels
//   (OBJ, SCR0, SCR1, SCR2). Each channel keeps a one-word tag/data
//   holding register; a request whose address matches the held tag is
//   answered at once, a miss is fetched through the single shared SDRAM
//   read port. At most one memory transaction is outstanding.
//
//   Optional feature: define RAIZING_GFXSRV_OBJ_PRIO_EN to give OBJ strict
//   priority over the scroll layers (see raizing_rr_arb4).
//
//   Ports:
//     CLK         in   1     system clock
//     RESET_N     in   1     synchronous active-low reset
//     INVALIDATE  in   1     pulse: drop every held word (ROM reload)
//     CH_CS       in   4     per-channel request strobe (bit0 = OBJ)
//     CH_ADDR     in   4*AW  per-channel word address, channel i at [i*AW +: AW]
//     CH_OK       out  4     held word matches current CH_ADDR (combinational)
//     CH_DOUT     out  4*DW  per-channel held data, channel i at [i*DW +: DW]
//     MEM_RD      out  1     memory read request
//     MEM_ADDR    out  AW    memory read address
//     MEM_ACK     in   1     memory accepted the request
//     MEM_DV      in   1     memory read data valid (one cycle)
//     MEM_DATA    in   DW    memory read data
//     DBG_STATE   out  2     current sequencer state (state_t encoding)
//
//   Memory handshake: MEM_RD rises with MEM_ADDR and both hold steady until
//   the cycle MEM_ACK is sampled high; MEM_RD then drops. Exactly one MEM_DV
//   follows, either in the ACK cycle itself or any later cycle. MEM_DV seen
//   outside that window (IDLE, or REQ without ACK) is ignored.
// ----------------------------------------------------------------------------
module raizing_gfx_rom_server
    import raizing_gfx_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
)
(
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              INVALIDATE,
    input  logic [NCH-1:0]    CH_CS,
    input  logic [NCH*AW-1:0] CH_ADDR,
    output logic [NCH-1:0]    CH_OK,
    output logic [NCH*DW-1:0] CH_DOUT,
    output logic              MEM_RD,
    output logic [AW-1:0]     MEM_ADDR,
    input  logic              MEM_ACK,
    input  logic              MEM_DV,
    input  logic [DW-1:0]     MEM_DATA,
    output logic [1:0]        DBG_STATE
);

    // Per-channel holding registers
    logic [AW-1:0]  tag   [NCH];
    logic [DW-1:0]  data  [NCH];
    logic [NCH-1:0] valid;

    // Sequencer state
    state_t         state;
    logic [1:0]     grant;
    logic [1:0]     rr_ptr;
    logic [AW-1:0]  lat_addr;
    logic           mem_rd;

    // Arbiter interface
    logic [NCH-1:0] pending;
    logic [NCH-1:0] grant_oh;
    logic [1:0]     grant_idx;
    logic           grant_any;
    logic [AW-1:0]  sel_addr;
    logic           capture;

    // OK is purely combinational from the held registers so it falls in the
    // same cycle the requester moves its address or drops CS.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign CH_OK[i]             = CH_CS[i] & valid[i] & (tag[i] == CH_ADDR[i*AW +: AW]);
        assign CH_DOUT[i*DW +: DW]  = data[i];
    end

    assign pending = CH_CS & ~CH_OK;

    raizing_rr_arb4 u_arb (
        .pending   (pending),
        .rr_ptr    (rr_ptr),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Address of the winning channel, latched when the request is launched.
    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant_idx == 2'(i)) begin
                sel_addr = CH_ADDR[i*AW +: AW];
            end
        end
    end

    // Data returns either together with the ACK or later while waiting.
    assign capture = MEM_DV && (((state == REQ) && MEM_ACK) || (state == WAIT));

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= 2'd3;
            lat_addr <= '0;
            mem_rd   <= 1'b0;
            valid    <= '0;
            for (int i = 0; i < NCH; i++) begin
                tag[i]  <= '0;
                data[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    mem_rd <= 1'b0;
                    if (grant_any) begin
                        grant    <= grant_idx;
                        lat_addr <= sel_addr;
                        mem_rd   <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (MEM_ACK) begin
                        mem_rd <= 1'b0;
                        state  <= MEM_DV ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (MEM_DV) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    mem_rd <= 1'b0;
                    state  <= IDLE;
                end
            endcase

            // The fill is tagged with the address that was launched, not the
            // channel's current address, so a requester that moved on sees a
            // mismatch and simply becomes pending again.
            if (capture) begin
                tag[grant]   <= lat_addr;
                data[grant]  <= MEM_DATA;
                valid[grant] <= 1'b1;
                rr_ptr       <= grant;
            end

            // Placed after the capture so an invalidate in the fill cycle
            // also clears the channel being filled.
            if (INVALIDATE) begin
                valid <= '0;
            end
        end
    end

    assign MEM_RD    = mem_rd;
    assign MEM_ADDR  = lat_addr;
    assign DBG_STATE = state;

endmodule

// File: tb/tb_raizing_gfx_rom_server.sv
module tb_raizing_gfx_rom_server;
  import raizing_gfx_pkg::*;

  localparam int AW  = 22;
  localparam int DW  = 32;
  localparam int LIM = 150;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic              invalidate;
  logic [3:0]        ch_cs;
  logic [4*AW-1:0]   ch_addr;
  logic [3:0]        ch_ok;
  logic [4*DW-1:0]   ch_dout;
  logic              mem_rd;
  logic [AW-1:0]     mem_addr;
  logic              mem_ack;
  logic              mem_dv;
  logic [DW-1:0]     mem_data;
  logic [1:0]        dbg_state;

  raizing_gfx_rom_server #(.AW(AW), .DW(DW)) dut (
    .CLK        (clk),
    .RESET_N    (reset_n),
    .INVALIDATE (invalidate),
    .CH_CS      (ch_cs),
    .CH_ADDR    (ch_addr),
    .CH_OK      (ch_ok),
    .CH_DOUT    (ch_dout),
    .MEM_RD     (mem_rd),
    .MEM_ADDR   (mem_addr),
    .MEM_ACK    (mem_ack),
    .MEM_DV     (mem_dv),
    .MEM_DATA   (mem_data),
    .DBG_STATE  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] rd_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory content: a fixed function of the address.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == 22'h000100) return 32'hDEADBEEF;
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [AW-1:0] get_addr(input int i);
    return ch_addr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] get_dout(input int i);
    return ch_dout[i*DW +: DW];
  endfunction

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    ch_addr[i*AW +: AW] = a;
  endtask

  function automatic logic [AW-1:0] pool_addr();
    return 22'($urandom_range(0, 7) * 32'h123 + 32'h40);
  endfunction

  // ---------------- memory responder (driver) ----------------
  bit            mem_auto = 0;
  bit            rand_mem = 0;
  bit            acked    = 0;
  int            ack_delay = 0, dv_gap = 1, ack_cnt = 0, dv_cnt = 0;
  logic [AW-1:0] dv_addr;

  task automatic mem_step();
    mem_ack = 1'b0;
    mem_dv  = 1'b0;
    if (dv_cnt > 0) begin
      dv_cnt--;
      if (dv_cnt == 0) begin
        mem_dv   = 1'b1;
        mem_data = mem_word(dv_addr);
      end
    end
    if (!mem_rd) begin
      acked = 0;
    end else if (!acked) begin
      if (ack_cnt < ack_delay) begin
        ack_cnt++;
      end else begin
        mem_ack = 1'b1;
        acked   = 1;
        ack_cnt = 0;
        rd_log.push_back(mem_addr);
        dv_addr = mem_addr;
        if (dv_gap == 0) begin
          mem_dv   = 1'b1;
          mem_data = mem_word(mem_addr);
        end else begin
          dv_cnt = dv_gap;
        end
        if (rand_mem) begin
          ack_delay = $urandom_range(0, 2);
          dv_gap    = $urandom_range(0, 3);
        end
      end
    end
  endtask

  task automatic mem_clear();
    acked = 0; ack_cnt = 0; dv_cnt = 0;
    mem_ack = 1'b0; mem_dv = 1'b0;
  endtask

  // One clock; returns just after the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    if (mem_auto) mem_step();
  endtask

  task automatic do_reset();
    mem_auto = 0;
    mem_clear();
    reset_n = 1'b0; ch_cs = '0; invalidate = 1'b0;
    cyc(); cyc();
    reset_n = 1'b1;
    rd_log.delete();
  endtask

  task automatic wait_ok(input int i, input string name);
    int n = 0;
    while (!ch_ok[i] && n < LIM) begin
      cyc();
      n++;
    end
    check(name, ch_ok[i], 1'b1);
  endtask

  // ---------------- table of hit vectors ----------------
  typedef struct {
    logic [3:0]    cs;
    logic [AW-1:0] a0, a1, a2, a3;
    logic [3:0]    ok;
  } vec_t;
  vec_t vecs[7];

  // random-phase model state
  bit            clean   [4];
  bit            unsure  [4];
  logic [AW-1:0] clean_a [4];
  int            wait_cnt[4];

  initial begin
    logic          prev_rd;
    logic [AW-1:0] prev_addr;
    logic [AW-1:0] a, na;
    logic          cs, ok, ncs, was_pend, busy;
    bit            moved;
    int            n, r;

    vecs[0] = '{4'hF, 22'h11, 22'h20, 22'h30, 22'h40, 4'hF};
    vecs[1] = '{4'h0, 22'h11, 22'h20, 22'h30, 22'h40, 4'h0};
    vecs[2] = '{4'h5, 22'h11, 22'h20, 22'h30, 22'h40, 4'h5};
    vecs[3] = '{4'hF, 22'h11, 22'h21, 22'h30, 22'h40, 4'hD};
    vecs[4] = '{4'hF, 22'h20, 22'h11, 22'h40, 22'h30, 4'h0};
    vecs[5] = '{4'h8, 22'h10, 22'h20, 22'h30, 22'h40, 4'h8};
    vecs[6] = '{4'hF, 22'h10, 22'h20, 22'h30, 22'h40, 4'hE};

    reset_n = 1'b0; invalidate = 1'b0; ch_cs = 4'hF; ch_addr = '0;
    mem_ack = 1'b0; mem_dv = 1'b0; mem_data = '0;

    // ---- reset state: tags are 0 but nothing is valid ----
    cyc(); cyc();
    check("rst_ok", ch_ok, 4'h0);
    check("rst_mem_rd", mem_rd, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_state", dbg_state, IDLE);
    ch_cs = '0;
    reset_n = 1'b1;
    cyc();

    // ---- test 1: first miss, ACK immediately, DV one cycle later ----
    mem_auto = 1; ack_delay = 0; dv_gap = 1;
    ch_cs = 4'b0001; set_addr(0, 22'h000100);
    cyc();
    check("t1_mem_rd", mem_rd, 1'b1);
    check("t1_mem_addr", mem_addr, 22'h000100);
    check("t1_ok_c1", ch_ok[0], 1'b0);
    cyc();
    check("t1_ok_c2", ch_ok[0], 1'b0);
    cyc();
    check("t1_ok_c3", ch_ok[0], 1'b1);
    check("t1_dout", get_dout(0), 32'hDEADBEEF);

    // ---- test 2: repeated address is a hit, no memory traffic ----
    for (int k = 0; k < 10; k++) begin
      cyc();
      check("t2_hit", {ch_ok[0], mem_rd}, 2'b10);
    end

    // ---- test 3: all four channels from rr_ptr = 3 ----
    do_reset();
    mem_auto = 1; ack_delay = 0; dv_gap = 1;
    set_addr(0, 22'h10); set_addr(1, 22'h20); set_addr(2, 22'h30); set_addr(3, 22'h40);
    ch_cs = 4'hF;
`ifdef RAIZING_GFXSRV_OBJ_PRIO_EN
    exp_q = '{22'h10, 22'h11, 22'h20, 22'h30, 22'h40};
`else
    exp_q = '{22'h10, 22'h20, 22'h30, 22'h40, 22'h11};
`endif
    moved = 0; n = 0;
    while (!(rd_log.size() >= 5 && ch_ok == 4'hF) && n < 200) begin
      cyc();
      n++;
      if (!moved && ch_ok[0]) begin
        set_addr(0, 22'h11);
        moved = 1;
      end
    end
    check("t3_reads", rd_log.size(), 5);
    for (int k = 0; k < 5; k++) begin
      check("t3_order", (k < rd_log.size()) ? rd_log[k] : 'x, exp_q.pop_front());
    end
    for (int i = 0; i < 4; i++) check("t3_dout", get_dout(i), mem_word(get_addr(i)));

    // ---- table: hit/miss decode against the four held words ----
    mem_auto = 0; mem_clear();
    foreach (vecs[v]) begin
      ch_cs = vecs[v].cs;
      set_addr(0, vecs[v].a0); set_addr(1, vecs[v].a1);
      set_addr(2, vecs[v].a2); set_addr(3, vecs[v].a3);
      #1;
      check("tbl_ok", ch_ok, vecs[v].ok);
      cyc();
    end
    check("tbl_dout1", get_dout(1), mem_word(22'h20));

    // ---- test 4: address moves while the fill is in WAIT ----
    do_reset();
    mem_auto = 1; ack_delay = 0; dv_gap = 2;
    ch_cs = 4'b0010; set_addr(1, 22'h20);
    cyc(); cyc();
    check("t4_state", dbg_state, WAIT);
    set_addr(1, 22'h24);
    cyc();
    check("t4_ok_wait", ch_ok[1], 1'b0);
    cyc();
    check("t4_ok_after_fill", ch_ok[1], 1'b0);
    check("t4_old_data", get_dout(1), mem_word(22'h20));
    dv_gap = 1;
    wait_ok(1, "t4_refetch_ok");
    check("t4_reads", rd_log.size(), 2);
    check("t4_second_addr", (rd_log.size() > 1) ? rd_log[1] : 'x, 22'h24);
    check("t4_dout", get_dout(1), mem_word(22'h24));

    // ---- test 5: INVALIDATE in the same cycle as the fill ----
    do_reset();
    ch_cs = 4'b0100; set_addr(2, 22'h30);
    cyc();
    check("t5_mem_rd", mem_rd, 1'b1);
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    check("t5_state", dbg_state, WAIT);
    mem_dv = 1'b1; mem_data = mem_word(22'h30); invalidate = 1'b1;
    cyc();
    mem_dv = 1'b0; invalidate = 1'b0;
    check("t5_ok", ch_ok[2], 1'b0);
    check("t5_idle", dbg_state, IDLE);
    cyc();
    check("t5_reread", {mem_rd, mem_addr}, {1'b1, 22'h30});
    mem_clear(); ack_delay = 0; dv_gap = 1; mem_auto = 1;
    wait_ok(2, "t5_refill_ok");

    // ---- test 6: reset in WAIT, stray DV afterwards ----
    do_reset();
    ch_cs = 4'b1000; set_addr(3, 22'h40);
    cyc();
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    check("t6_state_wait", dbg_state, WAIT);
    reset_n = 1'b0; ch_cs = '0;
    cyc();
    check("t6_state_rst", dbg_state, IDLE);
    check("t6_rd_rst", mem_rd, 1'b0);
    reset_n = 1'b1; mem_dv = 1'b1; mem_data = mem_word(22'h40);
    cyc();
    mem_dv = 1'b0;
    check("t6_state_idle", dbg_state, IDLE);
    check("t6_rd_idle", mem_rd, 1'b0);
    ch_cs = 4'b1000;
    #1;
    check("t6_stray_ignored", ch_ok, 4'h0);
    cyc();
    check("t6_new_req", mem_rd, 1'b1);
    mem_clear(); ack_delay = 0; dv_gap = 1; mem_auto = 1;
    wait_ok(3, "t6_fill_ok");

    // ---- random phase against the behavioural model ----
    do_reset();
    mem_auto = 1; rand_mem = 1; ack_delay = 1; dv_gap = 2;
    for (int i = 0; i < 4; i++) begin
      clean[i] = 0; unsure[i] = 0; clean_a[i] = '0; wait_cnt[i] = 0;
    end
    prev_rd = 1'b0; prev_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (mem_rd && prev_rd) check("mem_addr_stable", mem_addr, prev_addr);
      prev_rd = mem_rd; prev_addr = mem_addr;
      busy = mem_rd || (dv_cnt > 0) || mem_dv;
      if (!busy) for (int i = 0; i < 4; i++) unsure[i] = 0;
      invalidate = 1'b0;

      for (int i = 0; i < 4; i++) begin
        a = get_addr(i); cs = ch_cs[i]; ok = ch_ok[i];
        if (ok) begin
          check("rnd_ok_needs_cs", cs, 1'b1);
          check("rnd_dout", get_dout(i), mem_word(a));
          if (wait_cnt[i] > 0) check("rnd_latency_bound", wait_cnt[i] <= LIM, 1'b1);
          wait_cnt[i] = 0;
          if (!unsure[i]) begin
            clean[i] = 1; clean_a[i] = a;
          end
        end
        if (cs && clean[i] && a == clean_a[i]) check("rnd_hit", ok, 1'b1);
        was_pend = cs && !ok;
        if (was_pend) begin
          wait_cnt[i]++;
          if (wait_cnt[i] > LIM) begin
            check("rnd_timeout", 1'b0, 1'b1);
            ch_cs[i] = 1'b0; unsure[i] = 1; wait_cnt[i] = 0;
            continue;
          end
        end

        ncs = cs; na = a;
        r = $urandom_range(0, 99);
        if (was_pend) begin
          if (r < 3) na = pool_addr();
          else if (r < 5) ncs = 1'b0;
        end else if (cs) begin
          if (r < 20) ncs = 1'b0;
          else if (r < 35) na = pool_addr();
        end else if (r < 30) begin
          ncs = 1'b1;
          if ($urandom_range(0, 1) == 1) na = pool_addr();
        end
        if (was_pend && (ncs != cs || na != a)) unsure[i] = 1;
        if (ncs && na != clean_a[i]) clean[i] = 0;
        if (!ncs || na != a) wait_cnt[i] = 0;
        ch_cs[i] = ncs;
        set_addr(i, na);
      end

      if ($urandom_range(0, 99) == 0) begin
        invalidate = 1'b1;
        for (int i = 0; i < 4; i++) clean[i] = 0;
      end
    end
    invalidate = 1'b0;
    ch_cs = '0;
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
